pkt_rx_buffer: RTL and testbench
================================

PKT_RX_BUFFER -- requirements
Module: pkt_rx_buffer

Interface
REQ-001 Parameter: ETH_MTU, 1518, depth of payload buffer in bytes.
REQ-002 Parameter: ETHERTYPE, 16'h88B5, only EtherType accepted.
REQ-003 Parameter: MIN_PAYLOAD, 8, minimum accepted payload length in bytes.
REQ-004 Parameter: DOORBELL_CYCLES, 2, number of cycles the doorbell stays high.
REQ-005 Port: clock_in  input  1  sole clock; all logic on its rising edge.
REQ-006 Port: reset_in  input  1  asynchronous, active-low reset.
REQ-007 Port: rx_data_in  input  8  frame byte, MAC header first, FCS already removed.
REQ-008 Port: rx_valid_in  input  1  rx_data_in valid this cycle; no backpressure exists.
REQ-009 Port: rx_last_in  input  1  final byte of frame; qualified by rx_valid_in.
REQ-010 Port: rx_err_in  input  1  FCS/PHY error; sampled only with rx_valid_in && rx_last_in.
REQ-011 Port: pkt_buf_out  output  8 x ETH_MTU unpacked  payload bytes; payload byte k at index k.
REQ-012 Port: pkt_len_out  output  11  payload length of last accepted frame.
REQ-013 Port: pkt_buf_doorbell_out  output  1  high DOORBELL_CYCLES cycles per accepted frame.
REQ-014 Port: drop_count_out  output  16  rejected-frame count; saturates at 16'hFFFF.
REQ-015 Port: busy_out  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, HEADER, PAYLOAD, DISCARD, RING.
REQ-017 IDLE: valid byte without last -> HEADER, byte counter = 1; valid byte with last -> drop, stay IDLE.
REQ-018 HEADER SHALL count bytes 0..13; bytes 12,13 form the EtherType, big-endian.
- Byte 13 mismatching ETHERTYPE -> DISCARD.
- Otherwise -> PAYLOAD, payload index = 0.
REQ-019 PAYLOAD: each valid byte written to pkt_buf_out[index]; index increments.
REQ-020 The 1-cycle write-to-output latency means pkt_buf_out[k] updates the cycle after byte k is sampled.
REQ-021 A payload byte at index == ETH_MTU-14 (overflow) SHALL NOT be written; the frame goes to DISCARD.
REQ-022 On last in PAYLOAD, the frame SHALL be accepted iff rx_err_in == 0 and final length >= MIN_PAYLOAD.
REQ-023 Accept: the next cycle sets pkt_len_out = length and raises the doorbell, and the FSM enters RING.
REQ-024 Reject: drop_count_out increments the next cycle and the FSM returns to IDLE.
REQ-025 Last in HEADER (runt frame) SHALL be counted as a drop and the FSM SHALL return to IDLE.
REQ-026 DISCARD ignores bytes; on last -> count one drop, return to IDLE; exactly one drop per frame.
REQ-027 RING holds the doorbell high for exactly DOORBELL_CYCLES cycles, then drops it low and returns to IDLE.
- Doorbell SHALL be low at least 1 cycle between frames.
REQ-028 A valid byte arriving in RING SHALL mark that frame for discard.
- On RING exit -> DISCARD, or count the drop immediately if the byte carried last.
REQ-029 rx_valid_in low SHALL stall counters in every state; gaps inside a frame are legal.
REQ-030 pkt_buf_out bytes beyond pkt_len_out, and the contents after a rejected frame, are don't-care.
- Consumers sample only on the doorbell rising edge.
REQ-031 pkt_len_out SHALL change only on accept.
REQ-032 drop_count_out SHALL increment by at most 1 per cycle and hold at 16'hFFFF.

Reset
REQ-033 reset_in low SHALL asynchronously force IDLE.
- Doorbell 0, busy 0, pkt_len_out 0, drop_count_out 0, all counters 0.
REQ-034 pkt_buf_out contents SHALL NOT be reset.
REQ-035 Reset mid-frame SHALL abandon the frame without counting a drop.
- After release, bytes are treated as a new frame start.
REQ-036 Deassertion SHALL be synchronised so the FSM leaves reset on a clean clock edge.

Verification
REQ-037 Valid 22-byte frame, EtherType 88B5, payload 01..08 -> pkt_buf_out[0..7] = 01..08.
- pkt_len_out = 8, doorbell high cycles N+1..N+2, drop_count_out 0.
REQ-038 Same frame with EtherType 0800 -> no doorbell, drop_count_out = 1, pkt_len_out unchanged.
REQ-039 Frame with rx_err_in = 1 on last, then a 12-byte runt frame -> drop_count_out = 2, no doorbell.
REQ-040 1520-byte payload -> bytes 0..1503 written, frame discarded, drop_count_out +1.
- Next valid frame is accepted normally.
REQ-041 Second frame starting the cycle after the first's last byte -> first accepted, second counted as a drop.
- Doorbell pulses exactly once.
REQ-042 Reset asserted at payload byte 5, with drop_count_out preset to 16'hFFFF -> outputs zero, no doorbell.
- Separately, a further drop at saturation leaves drop_count_out at 16'hFFFF.

Source files
------------

// File: rtl/pkt_rx_buffer.sv
// Ethernet receive buffer: filters one EtherType, stores the payload and
// rings a doorbell per accepted frame; rejected frames bump a drop counter.
module pkt_rx_buffer #(
    parameter int          ETH_MTU         = 1518,
    parameter logic [15:0] ETHERTYPE       = 16'h88B5,
    parameter int          MIN_PAYLOAD     = 8,
    parameter int          DOORBELL_CYCLES = 2
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    input  logic        rx_last_in,
    input  logic        rx_err_in,
    output logic [7:0]  pkt_buf_out [ETH_MTU],
    output logic [10:0] pkt_len_out,
    output logic        pkt_buf_doorbell_out,
    output logic [15:0] drop_count_out,
    output logic        busy_out
);

    localparam logic [10:0] MAX_PAY = 11'(ETH_MTU - 14);
    localparam logic [10:0] MIN_LEN = 11'(MIN_PAYLOAD);
    localparam int          RW      = $clog2(DOORBELL_CYCLES + 1);
    localparam logic [RW-1:0] RING_LAST = RW'(DOORBELL_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DISCARD,
        RING
    } state_t;

    state_t        state;
    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [3:0]    hdr_cnt;
    logic [7:0]    etype_hi;
    logic [10:0]   pay_idx;
    logic [RW-1:0] ring_cnt;
    logic          ring_mark;

    logic [15:0] drop_inc;
    logic [10:0] next_len;
    logic        overflow;
    logic        accept;
    logic        etype_ok;
    logic        byte_last;

    // Assert asynchronously, release two edges later on a clean clock.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    assign drop_inc  = (drop_count_out == 16'hFFFF) ? drop_count_out
                                                    : drop_count_out + 16'd1;
    assign next_len  = pay_idx + 11'd1;
    assign overflow  = (pay_idx == MAX_PAY);
    assign accept    = !rx_err_in && (next_len >= MIN_LEN);
    assign etype_ok  = ({etype_hi, rx_data_in} == ETHERTYPE);
    assign byte_last = rx_valid_in && rx_last_in;
    assign busy_out  = (state != IDLE);

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clock_in) begin
        if (state == PAYLOAD && rx_valid_in && !overflow) begin
            pkt_buf_out[pay_idx] <= rx_data_in;
        end
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            hdr_cnt              <= '0;
            etype_hi             <= '0;
            pay_idx              <= '0;
            ring_cnt             <= '0;
            ring_mark            <= 1'b0;
            pkt_len_out          <= '0;
            pkt_buf_doorbell_out <= 1'b0;
            drop_count_out       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx_valid_in) begin
                        if (rx_last_in) begin
                            drop_count_out <= drop_inc;
                        end else begin
                            state   <= HEADER;
                            hdr_cnt <= 4'd1;
                        end
                    end
                end
                HEADER: begin
                    if (rx_valid_in) begin
                        hdr_cnt <= hdr_cnt + 4'd1;
                        if (hdr_cnt == 4'd12) etype_hi <= rx_data_in;
                        if (rx_last_in) begin
                            drop_count_out <= drop_inc;
                            state          <= IDLE;
                        end else if (hdr_cnt == 4'd13) begin
                            state   <= etype_ok ? PAYLOAD : DISCARD;
                            pay_idx <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_valid_in) begin
                        if (overflow) begin
                            if (rx_last_in) begin
                                drop_count_out <= drop_inc;
                                state          <= IDLE;
                            end else begin
                                state <= DISCARD;
                            end
                        end else begin
                            pay_idx <= next_len;
                            if (rx_last_in) begin
                                if (accept) begin
                                    pkt_len_out          <= next_len;
                                    pkt_buf_doorbell_out <= 1'b1;
                                    ring_cnt             <= RW'(1);
                                    ring_mark            <= 1'b0;
                                    state                <= RING;
                                end else begin
                                    drop_count_out <= drop_inc;
                                    state          <= IDLE;
                                end
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (byte_last) begin
                        drop_count_out <= drop_inc;
                        state          <= IDLE;
                    end
                end
                RING: begin
                    // A frame overlapping the doorbell is never stored.
                    if (byte_last) drop_count_out <= drop_inc;
                    if (ring_cnt == RING_LAST) begin
                        pkt_buf_doorbell_out <= 1'b0;
                        ring_mark            <= 1'b0;
                        if (rx_valid_in ? !rx_last_in : ring_mark) begin
                            state <= DISCARD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        ring_cnt <= ring_cnt + RW'(1);
                        if (rx_valid_in) ring_mark <= !rx_last_in;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_rx_buffer.sv
// Directed bench for pkt_rx_buffer: frame table plus corner-case sequences.
module tb_pkt_rx_buffer;

    localparam int MTU = 1518;

    logic        clock_in    = 1'b0;
    logic        reset_in    = 1'b0;
    logic [7:0]  rx_data_in  = 8'h00;
    logic        rx_valid_in = 1'b0;
    logic        rx_last_in  = 1'b0;
    logic        rx_err_in   = 1'b0;
    logic [7:0]  pkt_buf_out [MTU];
    logic [10:0] pkt_len_out;
    logic        pkt_buf_doorbell_out;
    logic [15:0] drop_count_out;
    logic        busy_out;

    int tests = 0;
    int fails = 0;
    int db_pulses = 0;
    int db_hi = 0;
    logic db_prev = 1'b0;

    typedef struct {
        logic [15:0] et;
        int          tot;
        logic        err;
        bit          gap;
        int          pulses;
        logic [10:0] len;
        logic [15:0] drop;
    } frm_t;

    frm_t tbl [9];

    pkt_rx_buffer dut (
        .clock_in             (clock_in),
        .reset_in             (reset_in),
        .rx_data_in           (rx_data_in),
        .rx_valid_in          (rx_valid_in),
        .rx_last_in           (rx_last_in),
        .rx_err_in            (rx_err_in),
        .pkt_buf_out          (pkt_buf_out),
        .pkt_len_out          (pkt_len_out),
        .pkt_buf_doorbell_out (pkt_buf_doorbell_out),
        .drop_count_out       (drop_count_out),
        .busy_out             (busy_out)
    );

    always #5 clock_in = ~clock_in;

    always @(negedge clock_in) begin
        if (pkt_buf_doorbell_out && !db_prev) db_pulses++;
        if (pkt_buf_doorbell_out) db_hi++;
        db_prev = pkt_buf_doorbell_out;
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [15:0] et,
                                           input int i);
        if (i < 12) return 8'(160 + i);
        if (i == 12) return et[15:8];
        if (i == 13) return et[7:0];
        return 8'(i - 13);
    endfunction

    task automatic drive(input logic [15:0] et, input int i, input int tot,
                         input logic err);
        rx_valid_in = 1'b1;
        rx_last_in  = (i == tot - 1);
        rx_err_in   = err && (i == tot - 1);
        rx_data_in  = byte_of(et, i);
        tick();
    endtask

    task automatic idle_in();
        rx_valid_in = 1'b0;
        rx_last_in  = 1'b0;
        rx_err_in   = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] et, input int tot,
                              input logic err, input bit gap);
        for (int i = 0; i < tot; i++) begin
            drive(et, i, tot, err);
            if (gap) begin
                rx_valid_in = 1'b0;
                tick();
            end
        end
        idle_in();
    endtask

    task automatic check_buf(input string nm, input int n);
        int bad;
        bad = -1;
        for (int k = 0; k < n; k++) begin
            if (pkt_buf_out[k] !== 8'(k + 1) && bad < 0) bad = k;
        end
        chk(nm, 32'(bad), 32'hFFFF_FFFF);
    endtask

    task automatic do_reset();
        idle_in();
        reset_in = 1'b0;
        repeat (3) tick();
        reset_in = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        int p0;
        int h0;
        int d0;

        tbl[0] = '{16'h88B5,   22, 1'b0, 1'b0, 1, 11'd8,  16'd0};
        tbl[1] = '{16'h0800,   22, 1'b0, 1'b0, 0, 11'd8,  16'd1};
        tbl[2] = '{16'h88B5,   22, 1'b1, 1'b0, 0, 11'd8,  16'd2};
        tbl[3] = '{16'h88B5,   12, 1'b0, 1'b0, 0, 11'd8,  16'd3};
        tbl[4] = '{16'h88B5,   21, 1'b0, 1'b0, 0, 11'd8,  16'd4};
        tbl[5] = '{16'h88B5,   34, 1'b0, 1'b1, 1, 11'd20, 16'd4};
        tbl[6] = '{16'h88B5, 1534, 1'b0, 1'b0, 0, 11'd20, 16'd5};
        tbl[7] = '{16'h88B5,   22, 1'b0, 1'b0, 1, 11'd8,  16'd5};
        tbl[8] = '{16'h88B5,   14, 1'b0, 1'b0, 0, 11'd8,  16'd6};

        repeat (2) tick();
        chk("rst_doorbell", 32'(pkt_buf_doorbell_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_len", 32'(pkt_len_out), 32'd0);
        chk("rst_drop", 32'(drop_count_out), 32'd0);
        reset_in = 1'b1;
        repeat (3) tick();

        for (int f = 0; f < 9; f++) begin
            p0 = db_pulses;
            h0 = db_hi;
            send_frame(tbl[f].et, tbl[f].tot, tbl[f].err, tbl[f].gap);
            repeat (5) tick();
            chk($sformatf("f%0d_pulses", f), 32'(db_pulses - p0),
                32'(tbl[f].pulses));
            chk($sformatf("f%0d_db_cycles", f), 32'(db_hi - h0),
                32'(2 * tbl[f].pulses));
            chk($sformatf("f%0d_len", f), 32'(pkt_len_out), 32'(tbl[f].len));
            chk($sformatf("f%0d_drop", f), 32'(drop_count_out),
                32'(tbl[f].drop));
            chk($sformatf("f%0d_busy", f), 32'(busy_out), 32'd0);
            if (tbl[f].pulses > 0) begin
                check_buf($sformatf("f%0d_buf", f), int'(tbl[f].len));
            end
            if (tbl[f].tot > MTU) begin
                chk("ovf_last_written", 32'(pkt_buf_out[1503]), 32'hE0);
            end
        end

        // Doorbell timing: high the two cycles after the last byte.
        send_frame(16'h88B5, 22, 1'b0, 1'b0);
        chk("db_cyc1", 32'(pkt_buf_doorbell_out), 32'd1);
        chk("busy_ring", 32'(busy_out), 32'd1);
        tick();
        chk("db_cyc2", 32'(pkt_buf_doorbell_out), 32'd1);
        tick();
        chk("db_cyc3", 32'(pkt_buf_doorbell_out), 32'd0);
        chk("busy_after_ring", 32'(busy_out), 32'd0);

        // Back-to-back frames: second one overlaps RING and is dropped.
        p0 = db_pulses;
        d0 = int'(drop_count_out);
        send_frame(16'h88B5, 22, 1'b0, 1'b0);
        send_frame(16'h88B5, 22, 1'b0, 1'b0);
        repeat (5) tick();
        chk("b2b_pulses", 32'(db_pulses - p0), 32'd1);
        chk("b2b_drop", 32'(drop_count_out), 32'(d0 + 1));
        chk("b2b_len", 32'(pkt_len_out), 32'd8);

        // One-byte frame during RING is counted at once; FSM then idles.
        p0 = db_pulses;
        send_frame(16'h88B5, 23, 1'b0, 1'b0);
        send_frame(16'h88B5, 1, 1'b0, 1'b0);
        chk("ring_last_drop", 32'(drop_count_out), 32'(d0 + 2));
        repeat (3) tick();
        send_frame(16'h88B5, 24, 1'b0, 1'b0);
        repeat (5) tick();
        chk("ring_last_pulses", 32'(db_pulses - p0), 32'd2);
        chk("ring_last_len", 32'(pkt_len_out), 32'd10);
        chk("ring_last_drop2", 32'(drop_count_out), 32'(d0 + 2));

        // Saturate the drop counter, then reset in the middle of a payload.
        do_reset();
        send_frame(16'h88B5, 22, 1'b0, 1'b0);
        repeat (4) tick();
        rx_valid_in = 1'b1;
        rx_last_in  = 1'b1;
        repeat (65535) tick();
        chk("sat_reach", 32'(drop_count_out), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(drop_count_out), 32'hFFFF);
        idle_in();
        tick();
        p0 = db_pulses;
        for (int i = 0; i < 20; i++) drive(16'h88B5, i, 30, 1'b0);
        reset_in = 1'b0;
        idle_in();
        #1;
        chk("mid_rst_drop", 32'(drop_count_out), 32'd0);
        chk("mid_rst_len", 32'(pkt_len_out), 32'd0);
        chk("mid_rst_busy", 32'(busy_out), 32'd0);
        chk("mid_rst_db", 32'(pkt_buf_doorbell_out), 32'd0);
        repeat (2) tick();
        reset_in = 1'b1;
        repeat (3) tick();
        chk("mid_rst_nodb", 32'(db_pulses - p0), 32'd0);
        send_frame(16'h88B5, 23, 1'b0, 1'b0);
        repeat (5) tick();
        chk("post_rst_pulses", 32'(db_pulses - p0), 32'd1);
        chk("post_rst_len", 32'(pkt_len_out), 32'd9);
        chk("post_rst_drop", 32'(drop_count_out), 32'd0);
        check_buf("post_rst_buf", 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
